aes128_iter_cipher: RTL and testbench



---
 rtl/aes128_iter_cipher.sv | 146 ++++++++++++++
 tb/tb_aes128_iter_cipher.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/aes128_iter_cipher.sv
// Iterative AES-128 encryption core: one round per clock, round keys expanded on the fly.
// Optional `AES_CIPHER_BUSY_EN adds a busy output; sequencing is identical without it.
module aes128_iter_cipher (
    input  logic         clk,
    input  logic         rstn,
    input  logic         start,
    input  logic [127:0] plain_text,
    input  logic [127:0] key,
`ifdef AES_CIPHER_BUSY_EN
    output logic         busy,
`endif
    output logic [127:0] cipher_text,
    output logic         done
);

    localparam logic [0:255][7:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} fsm_t;

    fsm_t         fsm_q;
    logic [127:0] state_q, state_d;
    logic [127:0] rkey_q, rkey_d;
    logic [127:0] ct_q;
    logic [3:0]   round_q;
    logic         done_q;

    logic [0:15][7:0] st, sb, sr, mc;
    logic [31:0]      w0, w1, w2, w3, tmp;
    logic [7:0]       rcon;

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[b];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] mixcol(input logic [31:0] c);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = c;
        return {xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
                a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
                a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
                xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    endfunction

    always_comb begin
        case (round_q)
            4'd1:    rcon = 8'h01;
            4'd2:    rcon = 8'h02;
            4'd3:    rcon = 8'h04;
            4'd4:    rcon = 8'h08;
            4'd5:    rcon = 8'h10;
            4'd6:    rcon = 8'h20;
            4'd7:    rcon = 8'h40;
            4'd8:    rcon = 8'h80;
            4'd9:    rcon = 8'h1b;
            4'd10:   rcon = 8'h36;
            default: rcon = 8'h00;
        endcase
    end

    // Byte 0 of the FIPS state sits in the MSB; column c holds bytes 4c..4c+3.
    always_comb begin
        st = state_q;
        sb = '0;
        sr = '0;
        mc = '0;
        for (int i = 0; i < 16; i++) sb[i] = sbox(st[i]);
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[4*c+r] = sb[4*((c+r)%4)+r];
        for (int c = 0; c < 4; c++)
            {mc[4*c], mc[4*c+1], mc[4*c+2], mc[4*c+3]} =
                mixcol({sr[4*c], sr[4*c+1], sr[4*c+2], sr[4*c+3]});

        {w0, w1, w2, w3} = rkey_q;
        tmp = {sbox(w3[23:16]), sbox(w3[15:8]), sbox(w3[7:0]), sbox(w3[31:24])}
              ^ {rcon, 24'h0};
        rkey_d = {w0 ^ tmp, w1 ^ w0 ^ tmp, w2 ^ w1 ^ w0 ^ tmp, w3 ^ w2 ^ w1 ^ w0 ^ tmp};

        // Last round drops MixColumns.
        state_d = ((round_q == 4'd10) ? sr : mc) ^ rkey_d;
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            fsm_q   <= S_IDLE;
            state_q <= '0;
            rkey_q  <= '0;
            ct_q    <= '0;
            round_q <= '0;
            done_q  <= 1'b0;
        end else begin
            case (fsm_q)
                S_IDLE: begin
                    if (start) begin
                        state_q <= plain_text ^ key;
                        rkey_q  <= key;
                        round_q <= 4'd1;
                        done_q  <= 1'b0;
                        fsm_q   <= S_RUN;
                    end
                end
                S_RUN: begin
                    state_q <= state_d;
                    rkey_q  <= rkey_d;
                    if (round_q == 4'd10) begin
                        ct_q    <= state_d;
                        done_q  <= 1'b1;
                        round_q <= '0;
                        fsm_q   <= S_IDLE;
                    end else begin
                        round_q <= round_q + 4'd1;
                    end
                end
                default: fsm_q <= S_IDLE;
            endcase
        end
    end

    assign cipher_text = ct_q;
    assign done        = done_q;
`ifdef AES_CIPHER_BUSY_EN
    assign busy        = (fsm_q == S_RUN);
`endif

endmodule

// File: tb/tb_aes128_iter_cipher.sv
// Self-checking bench for aes128_iter_cipher: known-answer vectors, control corner cases,
// and random vectors against a byte-array AES model whose S-box is derived from GF(2^8) math.
module tb_aes128_iter_cipher;

    logic         clk = 1'b0;
    logic         rstn;
    logic         start;
    logic [127:0] plain_text;
    logic [127:0] key;
    logic [127:0] cipher_text;
    logic         done;
`ifdef AES_CIPHER_BUSY_EN
    logic         busy;
`endif

    int checks = 0;
    int errors = 0;

    localparam logic [127:0] PT1 = 128'h00112233445566778899aabbccddeeff;
    localparam logic [127:0] K1  = 128'h000102030405060708090a0b0c0d0e0f;
    localparam logic [127:0] CT1 = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
    localparam logic [127:0] PT2 = 128'h3243f6a8885a308d313198a2e0370734;
    localparam logic [127:0] K2  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
    localparam logic [127:0] CT2 = 128'h3925841d02dc09fbdc118597196a0b32;
    localparam logic [127:0] CT0 = 128'h66e94bd4ef8a2c3b884cfa59ca342b2e;

    aes128_iter_cipher dut (
        .clk        (clk),
        .rstn       (rstn),
        .start      (start),
        .plain_text (plain_text),
        .key        (key),
`ifdef AES_CIPHER_BUSY_EN
        .busy       (busy),
`endif
        .cipher_text(cipher_text),
        .done       (done)
    );

    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    logic [7:0] sbt [256];

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p ^= a;
            a = (a << 1) ^ (a[7] ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int x = 0; x < 256; x++) begin
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
            sbt[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] round_key(input logic [127:0] k, input int rnd);
        logic [31:0] w [44];
        logic [31:0] t;
        logic [7:0]  rc = 8'h01;
        for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
        for (int i = 4; i < 44; i++) begin
            t = w[i-1];
            if (i % 4 == 0) begin
                t = {sbt[t[23:16]], sbt[t[15:8]], sbt[t[7:0]], sbt[t[31:24]]} ^ {rc, 24'h0};
                rc = gmul(rc, 8'h02);
            end
            w[i] = w[i-4] ^ t;
        end
        return {w[4*rnd], w[4*rnd+1], w[4*rnd+2], w[4*rnd+3]};
    endfunction

    function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] k);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [127:0] rk, res;
        for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ k[127-8*i -: 8];
        for (int rnd = 1; rnd <= 10; rnd++) begin
            for (int i = 0; i < 16; i++) t[i] = sbt[s[i]];
            for (int c = 0; c < 4; c++)
                for (int r = 0; r < 4; r++) s[4*c+r] = t[4*((c+r)%4)+r];
            if (rnd < 10) begin
                for (int c = 0; c < 4; c++)
                    for (int r = 0; r < 4; r++)
                        t[4*c+r] = gmul(8'h02, s[4*c+r]) ^ gmul(8'h03, s[4*c+(r+1)%4])
                                 ^ s[4*c+(r+2)%4] ^ s[4*c+(r+3)%4];
                for (int i = 0; i < 16; i++) s[i] = t[i];
            end
            rk = round_key(k, rnd);
            for (int i = 0; i < 16; i++) s[i] ^= rk[127-8*i -: 8];
        end
        for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
        return res;
    endfunction

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rnd128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Full operation; with junk set, start/inputs are scrambled while the core is busy.
    task automatic run_op(input logic [127:0] pt, input logic [127:0] k, input string tag,
                          input bit junk);
        plain_text = pt;
        key        = k;
        start      = 1'b1;
        tick();
        start = 1'b0;
        chk({tag, "_done_at_accept"}, done, 0);
        for (int i = 1; i <= 9; i++) begin
            if (junk) begin
                start      = 1'($urandom);
                plain_text = rnd128();
                key        = rnd128();
            end
            tick();
        end
        chk({tag, "_done_e9"}, done, 0);
        start = 1'b0;
        tick();
        chk({tag, "_done_e10"}, done, 1);
        chk({tag, "_ct"}, cipher_text, aes_ref(pt, k));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic seen;
        build_sbox();
        rstn = 1'b1; start = 1'b0; plain_text = '0; key = '0;
        repeat (3) tick();
        chk("reset_ct", cipher_text, 0);
        chk("reset_done", done, 0);

        // Start held during reset: nothing runs until reset drops.
        start = 1'b1; plain_text = PT1; key = K1;
        repeat (4) tick();
        chk("rst_hold_done", done, 0);
        chk("rst_hold_ct", cipher_text, 0);
        rstn = 1'b0;
        tick();
        repeat (9) tick();
        chk("hold_done_e9", done, 0);
        tick();
        chk("hold_done_e10", done, 1);
        chk("kat1_ct", cipher_text, CT1);
        // Start still high: re-accepted at once, done is a one-cycle pulse.
        tick();
        chk("hold_pulse_done", done, 0);
        chk("hold_ct_kept", cipher_text, CT1);
        repeat (9) tick();
        chk("hold2_done_e9", done, 0);
        tick();
        chk("hold2_done_e10", done, 1);
        chk("hold2_ct", cipher_text, CT1);
        start = 1'b0;
        repeat (3) tick();
        chk("idle_done_held", done, 1);
        chk("idle_ct_held", cipher_text, CT1);

        // FIPS-197 Appendix B vector with round-key intermediates.
        plain_text = PT2; key = K2; start = 1'b1;
        tick();
        start = 1'b0;
        chk("fips_rk0", dut.rkey_q, K2);
        tick();
        chk("fips_rk1", dut.rkey_q, 128'ha0fafe1788542cb123a339392a6c7605);
        chk("fips_rk1_model", dut.rkey_q, round_key(K2, 1));
        repeat (8) tick();
        chk("fips_done_e9", done, 0);
        tick();
        chk("fips_done", done, 1);
        chk("fips_ct", cipher_text, CT2);
        chk("fips_rk10", dut.rkey_q, 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);

        // All-zero vector, then back-to-back vector 1.
        run_op('0, '0, "zero", 1'b0);
        chk("zero_kat", cipher_text, CT0);
        run_op(PT1, K1, "again1", 1'b0);

        // Input change and re-pulse at E4 are ignored.
        plain_text = PT2; key = K2; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        plain_text = rnd128(); key = rnd128(); start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        chk("e4_done_e9", done, 0);
        tick();
        chk("e4_done", done, 1);
        chk("e4_ct", cipher_text, CT2);
        tick();
        chk("e4_no_second_op", done, 1);

        // Reset at E5 aborts the operation.
        plain_text = PT1; key = K1; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (4) tick();
        rstn = 1'b1;
        tick();
        chk("abort_ct", cipher_text, 0);
        chk("abort_done", done, 0);
        rstn = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen |= done;
        end
        chk("abort_no_done", seen, 0);
        run_op(rnd128(), rnd128(), "after_abort", 1'b0);

        // Random vectors with noise on inputs while busy.
        for (int n = 0; n < 8; n++) run_op(rnd128(), rnd128(), $sformatf("rand%0d", n), 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
